window_scan_ctrl: RTL

WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

---
 rtl/window_scan_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: walks a 3x3 window across an IMG_W x IMG_H image in raster
// order. Each row starts with a full 9-pixel load. Each step to the right
// shifts the window buffer and then loads only the new right-hand column.
// Every finished window is offered to the downstream stage with a
// valid/ready handshake.
module window_scan_ctrl #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        load_slot,
    output logic              start_read,
    input  logic              read_done,
    output logic              start_shift,
    output logic [1:0]        shift_direc,
    input  logic              shift_done,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [15:0]       win_row,
    output logic [15:0]       win_col
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FILL, PRESENT, DONE} state_t;

    // Address offsets of the second and third window rows. These are
    // constants, so no runtime multiplier is needed.
    localparam logic [ADDR_W-1:0] ROW1     = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW2     = ADDR_W'(2 * IMG_W);
    localparam logic [15:0]       COL_LAST = 16'(IMG_W - 3);
    localparam logic [15:0]       ROW_LAST = 16'(IMG_H - 3);

    state_t            state, state_nxt;
    logic              pend, pend_nxt;        // request issued, awaiting its done pulse
    logic [3:0]        idx, idx_nxt;          // position within the current read sequence
    logic [15:0]       row, row_nxt;
    logic [15:0]       col, col_nxt;
    logic [ADDR_W-1:0] row_base, row_base_nxt; // row * IMG_W, kept incrementally
    logic [ADDR_W-1:0] addr_nxt;
    logic [3:0]        slot_nxt;

    // Full load visits the bottom row first, then the middle row, then the top row.
    function automatic logic [3:0] load_order(input logic [3:0] i);
        case (i)
            4'd0:    return 4'd6;
            4'd1:    return 4'd7;
            4'd2:    return 4'd8;
            4'd3:    return 4'd3;
            4'd4:    return 4'd4;
            4'd5:    return 4'd5;
            4'd6:    return 4'd0;
            4'd7:    return 4'd1;
            default: return 4'd2;
        endcase
    endfunction

    // After a shift only the right-hand column (slots 8,5,2) needs new pixels.
    function automatic logic [3:0] fill_order(input logic [3:0] i);
        case (i)
            4'd0:    return 4'd8;
            4'd1:    return 4'd5;
            default: return 4'd2;
        endcase
    endfunction

    // Slot k maps to pixel (r + k/3, c + k%3).
    // base is r*IMG_W, so the pixel address is base + (k/3)*IMG_W + c + k%3.
    function automatic logic [ADDR_W-1:0] slot_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [15:0]       c,
                                                    input logic [3:0]        k);
        logic [ADDR_W-1:0] roff;
        logic [ADDR_W-1:0] coff;
        case (k)
            4'd0, 4'd1, 4'd2: roff = '0;
            4'd3, 4'd4, 4'd5: roff = ROW1;
            default:          roff = ROW2;
        endcase
        case (k)
            4'd0, 4'd3, 4'd6: coff = '0;
            4'd1, 4'd4, 4'd7: coff = ADDR_W'(1);
            default:          coff = ADDR_W'(2);
        endcase
        return base + roff + ADDR_W'(c) + coff;
    endfunction

    assign shift_direc = 2'b01;
    assign win_row     = row;
    assign win_col     = col;

    // State and counter registers; reset discards any outstanding request.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            pend      <= 1'b0;
            idx       <= '0;
            row       <= '0;
            col       <= '0;
            row_base  <= '0;
            rd_addr   <= '0;
            load_slot <= '0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            idx       <= idx_nxt;
            row       <= row_nxt;
            col       <= col_nxt;
            row_base  <= row_base_nxt;
            rd_addr   <= addr_nxt;
            load_slot <= slot_nxt;
        end
    end

    // Next-state, next-address and request outputs.
    // Done pulses are only looked at while pend is set in the matching state.
    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend;
        idx_nxt      = idx;
        row_nxt      = row;
        col_nxt      = col;
        row_base_nxt = row_base;
        addr_nxt     = rd_addr;
        slot_nxt     = load_slot;
        start_read   = 1'b0;
        start_shift  = 1'b0;
        win_valid    = 1'b0;
        busy         = 1'b1;
        frame_done   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    row_nxt      = '0;
                    col_nxt      = '0;
                    row_base_nxt = '0;
                    idx_nxt      = '0;
                    pend_nxt     = 1'b0;
                    addr_nxt     = slot_addr('0, 16'd0, 4'd6);
                    slot_nxt     = 4'd6;
                    state_nxt    = LOAD;
                end
            end
            LOAD: begin
                if (!pend) begin
                    start_read = 1'b1;
                    pend_nxt   = 1'b1;
                end else if (read_done) begin
                    pend_nxt = 1'b0;
                    if (idx == 4'd8) begin
                        idx_nxt   = '0;
                        state_nxt = PRESENT;
                    end else begin
                        idx_nxt  = idx + 4'd1;
                        slot_nxt = load_order(idx + 4'd1);
                        addr_nxt = slot_addr(row_base, col, load_order(idx + 4'd1));
                    end
                end
            end
            SHIFT: begin
                if (!pend) begin
                    start_shift = 1'b1;
                    pend_nxt    = 1'b1;
                end else if (shift_done) begin
                    pend_nxt  = 1'b0;
                    idx_nxt   = '0;
                    slot_nxt  = 4'd8;
                    addr_nxt  = slot_addr(row_base, col, 4'd8);
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (!pend) begin
                    start_read = 1'b1;
                    pend_nxt   = 1'b1;
                end else if (read_done) begin
                    pend_nxt = 1'b0;
                    if (idx == 4'd2) begin
                        idx_nxt   = '0;
                        state_nxt = PRESENT;
                    end else begin
                        idx_nxt  = idx + 4'd1;
                        slot_nxt = fill_order(idx + 4'd1);
                        addr_nxt = slot_addr(row_base, col, fill_order(idx + 4'd1));
                    end
                end
            end
            PRESENT: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    pend_nxt = 1'b0;
                    if (col < COL_LAST) begin
                        col_nxt   = col + 16'd1;
                        state_nxt = SHIFT;
                    end else if (row < ROW_LAST) begin
                        row_nxt      = row + 16'd1;
                        col_nxt      = '0;
                        row_base_nxt = row_base + ROW1;
                        idx_nxt      = '0;
                        addr_nxt     = slot_addr(row_base + ROW1, 16'd0, 4'd6);
                        slot_nxt     = 4'd6;
                        state_nxt    = LOAD;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                busy       = 1'b0;
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
